alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have port CLK  in  1  rising-edge clock.
REQ-002 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  in  1  decode presents an instruction.
REQ-004 SHALL have port in_ready  out  1  stage can accept an instruction this cycle.
REQ-005 SHALL have port in_aluop  in  aluop_t  ALU operation.
REQ-006 SHALL have ports in_rs, in_rt  in  regbits_t (5)  source register numbers.
REQ-007 SHALL have ports in_rdata1, in_rdata2  in  word_t (32)  register-file read data.
REQ-008 SHALL have ports in_imm  in  word_t and in_alusrc  in  1, where in_alusrc=1 selects imm for port_b.
REQ-009 SHALL have ports in_wsel  in  regbits_t and in_wen  in  1  destination register and write enable.
REQ-010 SHALL have port flush  in  1  discard the held instruction.
REQ-011 SHALL have ports mem_wen, mem_wsel, mem_wdata and mem_load  in  1/5/32/1  EX/MEM forwarding source; mem_load=1 means data not yet available.
REQ-012 SHALL have ports wb_wen, wb_wsel, wb_wdata  in  1/5/32  MEM/WB forwarding source.
REQ-013 SHALL have ports port_a, port_b  out  word_t and ALUOP  out  aluop_t  ALU operands and operation.
REQ-014 SHALL have ports out_valid  out  1 and out_ready  in  1  downstream handshake.
REQ-015 SHALL have ports out_wsel  out  regbits_t and out_wen  out  1  held destination.
REQ-016 SHALL have port stall_cnt  out  16  load-use stall cycle count.

Function
REQ-017 SHALL hold exactly one instruction in a register entry with a valid bit.
REQ-018 SHALL drive in_ready = !valid || (out_valid && out_ready), combinationally.
REQ-019 SHALL capture all in_* fields on a CLK edge when in_valid && in_ready.
REQ-020 SHALL forward per operand: on rs/rt match, MEM (mem_wen, mem_wsel) takes priority over WB (wb_wen, wb_wsel), otherwise the registered rdata is used.
REQ-021 SHALL never forward for register 0; operand is registered rdata (0).
REQ-022 SHALL drive port_b = held imm when alusrc=1, with no rt forwarding or hazard check on rt.
REQ-023 SHALL flag a hazard when valid && mem_wen && mem_load && mem_wsel!=0 && mem_wsel equals an operand actually used.
REQ-024 SHALL drive out_valid = valid && !hazard.
REQ-025 SHALL drive port_a/port_b/ALUOP/out_wsel/out_wen combinationally from the held entry, with zero added latency (0 cycles from held entry to ALU).
REQ-026 SHALL hold its contents and keep in_ready=0 while the entry is valid and either hazard=1 or out_ready=0.
REQ-027 SHALL increment stall_cnt by 1 each cycle hazard=1, saturating at 0xFFFF.
REQ-028 SHALL clear valid on a flush edge, overriding a simultaneous load: an incoming in_valid that cycle is dropped.
REQ-029 SHALL force out_wen=0 whenever valid=0.
REQ-030 SHALL accept a new instruction in the same cycle the old one departs (full throughput, no bubble).

Reset
REQ-031 SHALL, on RST=1 and independent of CLK, clear valid, held fields and stall_cnt to 0.
REQ-032 SHALL show out_valid=0, port_a=0, port_b=0, ALUOP=0 encoding, out_wen=0 and in_ready=1 while RST=1.
REQ-033 SHALL discard an instruction in flight at a mid-operation reset; nothing replays.

Structure
REQ-034 SHALL use word_t, aluop_t and regbits_t from cpu_types_pkg; new fwd_sel_t {FWD_REG, FWD_MEM, FWD_WB} SHALL be added there.
REQ-035 SHALL implement forwarding selection as sub-module alu_fwd_mux (combinational), instantiated once per operand.

Verification
REQ-036 SHALL verify no-hazard flow: ADD with rdata1=5, rdata2=7, out_ready=1 -> port_a=5, port_b=7, out_valid=1 the cycle after capture.
REQ-037 SHALL verify forward priority: rs=3, mem_wsel=3 mem_wdata=0xAA, wb_wsel=3 wb_wdata=0xBB -> port_a=0xAA; with mem_wen=0 -> 0xBB.
REQ-038 SHALL verify load-use: rt=4, mem_load=1 mem_wsel=4 for 2 cycles -> out_valid=0, in_ready=0 for 2 cycles, stall_cnt=2, then out_valid=1.
REQ-039 SHALL verify register-zero and immediate: rs=0, mem_wsel=0 mem_wdata=0xFF -> port_a=0; alusrc=1 imm=0x10 with rt hazard -> port_b=0x10 and no stall.
REQ-040 SHALL verify flush/backpressure: out_ready=0 holds the entry and in_ready=0; flush with in_valid=1 -> valid=0 next cycle and the new instruction dropped.
REQ-041 SHALL verify async reset: RST pulsed mid-cycle while valid -> out_valid=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU datapath types: words, register numbers, ALU
//                operations and operand-forwarding source selection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/alu_fwd_mux.sv
// ============================================================================
//  Module      : alu_fwd_mux
//  Description : Combinational per-operand bypass select (MEM over WB over RF).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_fwd_mux
  import cpu_types_pkg::*;
(
  input  regbits_t src_reg,
  input  word_t    reg_data,
  input  logic     mem_wen,
  input  regbits_t mem_wsel,
  input  word_t    mem_wdata,
  input  logic     wb_wen,
  input  regbits_t wb_wsel,
  input  word_t    wb_wdata,
  output word_t    fwd_data
);

  fwd_sel_t w_sel;

  // Register 0 is hard-wired zero, so it is never a bypass target.
  always_comb begin
    w_sel = FWD_REG;
    if (src_reg != '0) begin
      if (mem_wen && (mem_wsel == src_reg)) begin
        w_sel = FWD_MEM;
      end else if (wb_wen && (wb_wsel == src_reg)) begin
        w_sel = FWD_WB;
      end
    end
  end

  always_comb begin
    case (w_sel)
      FWD_MEM: fwd_data = mem_wdata;
      FWD_WB:  fwd_data = wb_wdata;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Single-entry ALU operand stage with bypassing, load-use stall
//                detection, flush and a saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  aluop_t      in_aluop,
  input  regbits_t    in_rs,
  input  regbits_t    in_rt,
  input  word_t       in_rdata1,
  input  word_t       in_rdata2,
  input  word_t       in_imm,
  input  logic        in_alusrc,
  input  regbits_t    in_wsel,
  input  logic        in_wen,
  input  logic        flush,
  input  logic        mem_wen,
  input  regbits_t    mem_wsel,
  input  word_t       mem_wdata,
  input  logic        mem_load,
  input  logic        wb_wen,
  input  regbits_t    wb_wsel,
  input  word_t       wb_wdata,
  output word_t       port_a,
  output word_t       port_b,
  output aluop_t      ALUOP,
  output logic        out_valid,
  input  logic        out_ready,
  output regbits_t    out_wsel,
  output logic        out_wen,
  output logic [15:0] stall_cnt
);

  logic     r_valid;
  aluop_t   r_aluop;
  regbits_t r_rs;
  regbits_t r_rt;
  word_t    r_rdata1;
  word_t    r_rdata2;
  word_t    r_imm;
  logic     r_alusrc;
  regbits_t r_wsel;
  logic     r_wen;
  logic [15:0] r_stall_cnt;

  word_t w_fwd_a;
  word_t w_fwd_b;
  logic  w_hazard;
  logic  w_out_valid;
  logic  w_in_ready;
  logic  w_load;
  logic  w_depart;

  alu_fwd_mux u_fwd_a (
    .src_reg   (r_rs),
    .reg_data  (r_rdata1),
    .mem_wen   (mem_wen),
    .mem_wsel  (mem_wsel),
    .mem_wdata (mem_wdata),
    .wb_wen    (wb_wen),
    .wb_wsel   (wb_wsel),
    .wb_wdata  (wb_wdata),
    .fwd_data  (w_fwd_a)
  );

  alu_fwd_mux u_fwd_b (
    .src_reg   (r_rt),
    .reg_data  (r_rdata2),
    .mem_wen   (mem_wen),
    .mem_wsel  (mem_wsel),
    .mem_wdata (mem_wdata),
    .wb_wen    (wb_wen),
    .wb_wsel   (wb_wsel),
    .wb_wdata  (wb_wdata),
    .fwd_data  (w_fwd_b)
  );

  // rt only counts as a consumer when the immediate is not selected.
  assign w_hazard = r_valid && mem_wen && mem_load && (mem_wsel != '0) &&
                    ((mem_wsel == r_rs) || (!r_alusrc && (mem_wsel == r_rt)));

  assign w_out_valid = r_valid && !w_hazard;
  assign w_depart    = w_out_valid && out_ready;
  assign w_in_ready  = !r_valid || w_depart;
  assign w_load      = in_valid && w_in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid  <= 1'b0;
      r_aluop  <= aluop_t'(4'd0);
      r_rs     <= '0;
      r_rt     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_alusrc <= 1'b0;
      r_wsel   <= '0;
      r_wen    <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid  <= 1'b1;
        r_aluop  <= in_aluop;
        r_rs     <= in_rs;
        r_rt     <= in_rt;
        r_rdata1 <= in_rdata1;
        r_rdata2 <= in_rdata2;
        r_imm    <= in_imm;
        r_alusrc <= in_alusrc;
        r_wsel   <= in_wsel;
        r_wen    <= in_wen;
      end else if (w_depart) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != c_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign port_a    = w_fwd_a;
  assign port_b    = r_alusrc ? r_imm : w_fwd_b;
  assign ALUOP     = r_aluop;
  assign out_wsel  = r_wsel;
  assign out_wen   = r_valid && r_wen;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Scoreboard bench for alu_operand_stage with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  aluop_t      in_aluop;
  regbits_t    in_rs, in_rt;
  word_t       in_rdata1, in_rdata2, in_imm;
  logic        in_alusrc;
  regbits_t    in_wsel;
  logic        in_wen;
  logic        flush;
  logic        mem_wen;
  regbits_t    mem_wsel;
  word_t       mem_wdata;
  logic        mem_load;
  logic        wb_wen;
  regbits_t    wb_wsel;
  word_t       wb_wdata;
  word_t       port_a, port_b;
  aluop_t      ALUOP;
  logic        out_valid;
  logic        out_ready;
  regbits_t    out_wsel;
  logic        out_wen;
  logic [15:0] stall_cnt;

  alu_operand_stage dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs(in_rs), .in_rt(in_rt), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_wsel(in_wsel), .in_wen(in_wen),
    .flush(flush),
    .mem_wen(mem_wen), .mem_wsel(mem_wsel), .mem_wdata(mem_wdata), .mem_load(mem_load),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdata(wb_wdata),
    .port_a(port_a), .port_b(port_b), .ALUOP(ALUOP),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wsel(out_wsel), .out_wen(out_wen), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    aluop_t   op;
    regbits_t rs, rt;
    word_t    d1, d2, imm;
    logic     alusrc;
    regbits_t wsel;
    logic     wen;
  } instr_t;

  instr_t held[$];
  int unsigned m_stalls;
  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Bypass rule: reg 0 never bypassed; MEM result beats WB result beats RF data.
  function automatic word_t ref_operand(regbits_t r, word_t rf);
    if (r == 0) return rf;
    if (mem_wen && mem_wsel == r) return mem_wdata;
    if (wb_wen && wb_wsel == r) return wb_wdata;
    return rf;
  endfunction

  // Monitor: compare against the model, then advance it to the next edge.
  always @(negedge CLK) begin
    if (RST) begin
      held.delete();
      m_stalls = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_port_a", port_a, 32'd0);
      chk("rst_port_b", port_b, 32'd0);
      chk("rst_aluop", 32'(ALUOP), 32'd0);
      chk("rst_out_wen", 32'(out_wen), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    end else begin
      instr_t e;
      logic has, hz, ov, ir;
      has = (held.size() != 0);
      if (has) e = held[0];
      hz = has && mem_wen && mem_load && (mem_wsel != 0) &&
           ((mem_wsel == e.rs) || (!e.alusrc && (mem_wsel == e.rt)));
      ov = has && !hz;
      ir = !has || (ov && out_ready);
      chk("stall_cnt", 32'(stall_cnt), m_stalls);
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("in_ready", 32'(in_ready), 32'(ir));
      chk("out_wen", 32'(out_wen), 32'(has && e.wen));
      if (ov) begin
        chk("port_a", port_a, ref_operand(e.rs, e.d1));
        chk("port_b", port_b, e.alusrc ? e.imm : ref_operand(e.rt, e.d2));
        chk("aluop", 32'(ALUOP), 32'(e.op));
        chk("out_wsel", 32'(out_wsel), 32'(e.wsel));
      end
      if (hz && m_stalls != 32'hFFFF) m_stalls++;
      if (flush) begin
        held.delete();
      end else begin
        if (ov && out_ready) void'(held.pop_front());
        if (in_valid && ir) begin
          instr_t n;
          n.op = in_aluop; n.rs = in_rs; n.rt = in_rt;
          n.d1 = in_rdata1; n.d2 = in_rdata2; n.imm = in_imm;
          n.alusrc = in_alusrc; n.wsel = in_wsel; n.wen = in_wen;
          held.push_back(n);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1;
    mem_wen = 0; mem_load = 0; mem_wsel = 0; mem_wdata = 0;
    wb_wen = 0; wb_wsel = 0; wb_wdata = 0;
  endtask

  task automatic issue(aluop_t op, regbits_t rs, regbits_t rt, word_t d1, word_t d2,
                       logic src, word_t imm);
    in_valid = 1; in_aluop = op; in_rs = rs; in_rt = rt;
    in_rdata1 = d1; in_rdata2 = d2; in_alusrc = src; in_imm = imm;
    in_wsel = 5'd9; in_wen = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    RST = 1;
    idle();
    issue(ALU_ADD, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    repeat (2) step();
    RST = 0;
    step();

    // No-hazard flow.
    issue(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 32'd0);
    step();
    in_valid = 0;
    chk("flow_valid", 32'(out_valid), 32'd1);
    chk("flow_a", port_a, 32'd5);
    chk("flow_b", port_b, 32'd7);
    step();

    // Forwarding priority, entry held with out_ready low.
    issue(ALU_SUB, 5'd3, 5'd2, 32'd1, 32'd2, 1'b0, 32'd0);
    step();
    in_valid = 0; out_ready = 0;
    mem_wen = 1; mem_wsel = 5'd3; mem_wdata = 32'hAA;
    wb_wen = 1; wb_wsel = 5'd3; wb_wdata = 32'hBB;
    #1 chk("fwd_mem", port_a, 32'hAA);
    mem_wen = 0;
    #1 chk("fwd_wb", port_a, 32'hBB);
    step();
    idle();
    step();

    // Load-use on rt for two cycles.
    issue(ALU_OR, 5'd1, 5'd4, 32'd3, 32'd4, 1'b0, 32'd0);
    step();
    in_valid = 0;
    mem_wen = 1; mem_load = 1; mem_wsel = 5'd4; mem_wdata = 32'h44;
    base = m_stalls;
    #1 chk("lu_valid0", 32'(out_valid), 32'd0);
    chk("lu_ready0", 32'(in_ready), 32'd0);
    step();
    chk("lu_valid1", 32'(out_valid), 32'd0);
    chk("lu_ready1", 32'(in_ready), 32'd0);
    step();
    mem_load = 0;
    #1 chk("lu_release", 32'(out_valid), 32'd1);
    chk("lu_stalls", 32'(stall_cnt), base + 2);
    step();
    idle();

    // Register zero and immediate operand.
    issue(ALU_AND, 5'd0, 5'd4, 32'd0, 32'd8, 1'b1, 32'h10);
    step();
    in_valid = 0; out_ready = 0;
    mem_wen = 1; mem_wsel = 5'd0; mem_wdata = 32'hFF;
    #1 chk("r0_a", port_a, 32'd0);
    mem_load = 1; mem_wsel = 5'd4;
    #1 chk("imm_b", port_b, 32'h10);
    chk("imm_nostall", 32'(out_valid), 32'd1);
    step();
    idle();
    step();

    // Backpressure then flush with a simultaneous incoming instruction.
    issue(ALU_XOR, 5'd5, 5'd6, 32'h55, 32'h66, 1'b0, 32'd0);
    step();
    in_valid = 0; out_ready = 0;
    step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ready", 32'(in_ready), 32'd0);
    flush = 1;
    issue(ALU_NOR, 5'd7, 5'd1, 32'h77, 32'h11, 1'b0, 32'd0);
    step();
    idle();
    #1 chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    step();

    // Asynchronous reset while an entry is held and stalls have accrued.
    issue(ALU_SLT, 5'd2, 5'd3, 32'h2, 32'h3, 1'b0, 32'd0);
    step();
    in_valid = 0; mem_wen = 1; mem_load = 1; mem_wsel = 5'd2;
    step();
    #1 RST = 1;
    #1 chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_a", port_a, 32'd0);
    idle();
    step();
    RST = 0;
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_aluop  = aluop_t'(4'($urandom_range(0, 9)));
      in_rs     = regbits_t'($urandom_range(0, 7));
      in_rt     = regbits_t'($urandom_range(0, 7));
      in_rdata1 = $urandom;
      in_rdata2 = $urandom;
      in_imm    = $urandom;
      in_alusrc = ($urandom_range(0, 1) != 0);
      in_wsel   = regbits_t'($urandom_range(0, 31));
      in_wen    = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mem_wen   = ($urandom_range(0, 1) != 0);
      mem_wsel  = regbits_t'($urandom_range(0, 7));
      mem_wdata = $urandom;
      mem_load  = ($urandom_range(0, 3) == 0);
      wb_wen    = ($urandom_range(0, 1) != 0);
      wb_wsel   = regbits_t'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      step();
    end
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
